urng_scheduler: RTL and testbench
=================================

Name: urng_scheduler

Overview:
Controller that seeds, warms up and time-shares one Tausworthe URNG instance among NUM_REQ requesters. It sequences seed loading and discards the generator's first WARMUP outputs. A round-robin arbiter then delivers one fresh 32-bit word per cycle to one granted requester. It sits between the AWGN datapath consumers (Box-Muller units, test taps) and the uniform generator.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WARMUP, 8, generator cycles discarded after every seed load (1..255)
DEF_SEED1, 32'h0000_1234, default/fallback seed for s0 (must be > 1)
DEF_SEED2, 32'h0000_5678, default/fallback seed for s1 (must be > 7)
DEF_SEED3, 32'h0009_ABCD, default/fallback seed for s2 (must be > 15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
seed_load  input  1  one-cycle pulse: reseed with seed1..seed3
seed1  input  32  seed for s0
seed2  input  32  seed for s1
seed3  input  32  seed for s2
req  input  NUM_REQ  per-requester word request, level, held while words are wanted
rnd_valid  output  NUM_REQ  one-hot: word on rnd_data belongs to requester i this cycle
rnd_data  output  32  registered uniform word
rnd_ready  output  1  high in RUN state only
seed_err  output  1  sticky: last seed set contained an illegal value; fallback used
word_count  output  32  words delivered since last seed load, wraps at 2^32

Behaviour:
- Decided: one clock, clk; reset is synchronous, active-low, port named reset. All state updates occur on posedge clk only.
- Reset (reset==0 at a posedge): state=LOAD with DEF_SEED1..3 selected. Outputs: rnd_valid=0, rnd_data=0, rnd_ready=0, seed_err=0, word_count=0, rr pointer=0.
- FSM states: LOAD, WARM, RUN.
- LOAD (1 cycle): registered gen_rst=1 drives generator seed load with the latched seeds. Next state is WARM, with warm_cnt=WARMUP-1.
- WARM: warm_cnt decrements each cycle. At 0, next state is RUN. No grants are issued in WARM.
- RUN: rnd_ready=1. Grants are issued as described below.
- seed_load=1 in any state:
  - latch seeds (with sanitising), go to LOAD next cycle;
  - clear rnd_valid on that same edge;
  - clear word_count and warm_cnt.
  - Reset has priority over seed_load.
- Seed sanitising (per word, independent):
  - seed1<2 is replaced by DEF_SEED1;
  - seed2<8 is replaced by DEF_SEED2;
  - seed3<16 is replaced by DEF_SEED3.
  - Any replacement sets seed_err=1. A later legal seed_load clears seed_err.
- Arbitration (RUN, no seed_load):
  - Sample req; grant the first asserted requester at or after rr pointer, index order with wrap.
  - At the next edge: rnd_valid = one-hot(grant), rnd_data = generator output of the granting cycle, word_count += 1, rr pointer = grant+1 mod NUM_REQ.
  - Latency is 1 cycle: req sampled at edge k, word at edge k+1.
  - No req means rnd_valid=0, pointer unchanged, rnd_data holds its last value.
- The generator free-runs every cycle. Words in non-granted cycles are discarded. No word is ever delivered twice.
- Fairness: with all requesters continuously asserted, grants cycle 0,1,..,NUM_REQ-1,0,…. Any requester holding req waits at most NUM_REQ-1 cycles.
- req deasserted: takes effect on the next sample. There is no handshake back-pressure; a requester must accept rnd_valid when it is asserted.
- word_count wraps 32'hFFFF_FFFF → 0 silently.

Decomposition:
- Package urng_pkg: FSM state enum (LOAD, WARM, RUN), seed minimum constants (2, 8, 16), default seed constants, and a round-robin pick function.
- Sub-module: the existing taus generator, one instance. Seeds come from the latched sanitised registers; its active-high reset is driven by registered gen_rst, glitch-free.
- Arbiter logic stays inline; it is small.

Test Plan:
1. Release reset, no seed_load, WARMUP=8 → rnd_ready rises exactly 1+8 cycles after the first edge with reset=1; first granted word equals the golden model's 10th generator output from the default seeds.
2. req=4'b1111 held for 8 cycles in RUN → rnd_valid sequence 0001,0010,0100,1000,0001,0010,0100,1000; word_count=8; words match consecutive golden outputs.
3. req=4'b0100 then 4'b1001 → grants 2, then 3, then 0; pointer wrap is verified.
4. seed_load with seed1=1, seed2=100, seed3=5 → seed_err=1 and DEF_SEED1/DEF_SEED3 are used; a later seed_load with 2,8,16 → seed_err=0.
5. seed_load mid-RUN with req=4'b1111 → rnd_valid=0 on that edge; word_count=0; rnd_ready low for 1+WARMUP cycles; the stream restarts at the golden output for the new seeds.
6. reset=0 asserted mid-RUN for 1 cycle → all outputs at reset values next edge; the LOAD→WARM→RUN sequence repeats with default seeds.

Source files
------------

// File: rtl/urng_pkg.sv
// Shared definitions for the URNG scheduler.
//   - urng_state_e : sequencing states (load seeds, warm up, run)
//   - SEEDn_MIN    : smallest legal value of each Tausworthe seed word
//   - DEF_SEEDn_C  : default/fallback seed words
//   - rr_pick      : round-robin search over up to RR_MAX requesters
package urng_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } urng_state_e;

  localparam int unsigned RR_MAX = 8;

  // A seed word below its minimum leaves the component stuck in a short cycle.
  localparam logic [31:0] SEED1_MIN = 32'd2;
  localparam logic [31:0] SEED2_MIN = 32'd8;
  localparam logic [31:0] SEED3_MIN = 32'd16;

  localparam logic [31:0] DEF_SEED1_C = 32'h0000_1234;
  localparam logic [31:0] DEF_SEED2_C = 32'h0000_5678;
  localparam logic [31:0] DEF_SEED3_C = 32'h0009_ABCD;

  // First asserted index at or after ptr, wrapping at n (n <= RR_MAX).
  // Returns ptr when nothing is requested; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/urng_scheduler_taus.sv
// Three-component Tausworthe uniform generator (taus88 recurrences).
// Free-runs one step per clock. While gen_rst is high the seed inputs replace
// the state, so the load cycle already presents the first output of the new
// seed set and the state register takes the stepped seeds.
// Ports:
//   clk       system clock
//   gen_rst   active-high synchronous seed load (driven from a flop)
//   seed1..3  seed words for components s0..s2
//   rnd       32-bit uniform output of the current step
module urng_scheduler_taus (
  input  logic        clk,
  input  logic        gen_rst,
  input  logic [31:0] seed1,
  input  logic [31:0] seed2,
  input  logic [31:0] seed3,
  output logic [31:0] rnd
);

  logic [31:0] s0_q, s1_q, s2_q;
  logic [31:0] s0_d, s1_d, s2_d;
  logic [31:0] s0_cur, s1_cur, s2_cur;

  always_comb begin
    s0_cur = gen_rst ? seed1 : s0_q;
    s1_cur = gen_rst ? seed2 : s1_q;
    s2_cur = gen_rst ? seed3 : s2_q;
    s0_d   = ((s0_cur & 32'hFFFF_FFFE) << 12) ^ (((s0_cur << 13) ^ s0_cur) >> 19);
    s1_d   = ((s1_cur & 32'hFFFF_FFF8) << 4)  ^ (((s1_cur << 2)  ^ s1_cur) >> 25);
    s2_d   = ((s2_cur & 32'hFFFF_FFF0) << 17) ^ (((s2_cur << 3)  ^ s2_cur) >> 11);
    rnd    = s0_d ^ s1_d ^ s2_d;
  end

  always_ff @(posedge clk) begin
    s0_q <= s0_d;
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

endmodule

// File: rtl/urng_scheduler.sv
// Seeds, warms up and time-shares one Tausworthe generator among NUM_REQ
// requesters. After every seed load the generator output of the load cycle and
// of WARMUP warm-up cycles is discarded; then a round-robin arbiter hands one
// fresh word per cycle to one requester, one cycle after sampling req.
//
//   state | meaning
//   LOAD  | gen_rst high, generator takes the latched seed set (1 cycle)
//   WARM  | warm_cnt counts WARMUP-1..0, generator output discarded
//   RUN   | rnd_ready high, one grant per cycle from req
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   seed_load   one-cycle pulse, reseed from seed1..seed3
//   seed1..3    candidate seed words (sanitised on load)
//   req         per-requester level request
//   rnd_valid   one-hot owner of rnd_data this cycle
//   rnd_data    registered uniform word
//   rnd_ready   high in RUN
//   seed_err    sticky: last seed set needed a fallback value
//   word_count  words delivered since last seed load (wraps)
module urng_scheduler
  import urng_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WARMUP    = 8,
  parameter logic [31:0] DEF_SEED1 = DEF_SEED1_C,
  parameter logic [31:0] DEF_SEED2 = DEF_SEED2_C,
  parameter logic [31:0] DEF_SEED3 = DEF_SEED3_C
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_load,
  input  logic [31:0]        seed1,
  input  logic [31:0]        seed2,
  input  logic [31:0]        seed3,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rnd_valid,
  output logic [31:0]        rnd_data,
  output logic               rnd_ready,
  output logic               seed_err,
  output logic [31:0]        word_count
);

  urng_state_e        state_q, state_d;
  logic [7:0]         warm_cnt_q, warm_cnt_d;
  logic [31:0]        seed1_q, seed1_d;
  logic [31:0]        seed2_q, seed2_d;
  logic [31:0]        seed3_q, seed3_d;
  logic               seed_err_q, seed_err_d;
  logic               gen_rst_q, gen_rst_d;
  logic [NUM_REQ-1:0] rnd_valid_q, rnd_valid_d;
  logic [31:0]        rnd_data_q, rnd_data_d;
  logic [31:0]        word_count_q, word_count_d;
  logic [2:0]         ptr_q, ptr_d;

  logic [31:0]        gen_rnd;
  logic [2:0]         grant;
  logic               bad1, bad2, bad3;

  urng_scheduler_taus u_taus (
    .clk     (clk),
    .gen_rst (gen_rst_q),
    .seed1   (seed1_q),
    .seed2   (seed2_q),
    .seed3   (seed3_q),
    .rnd     (gen_rnd)
  );

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    seed1_d      = seed1_q;
    seed2_d      = seed2_q;
    seed3_d      = seed3_q;
    seed_err_d   = seed_err_q;
    gen_rst_d    = 1'b0;
    rnd_valid_d  = '0;
    rnd_data_d   = rnd_data_q;
    word_count_d = word_count_q;
    ptr_d        = ptr_q;
    grant        = rr_pick(8'(req), ptr_q, 4'(NUM_REQ));
    bad1         = seed1 < SEED1_MIN;
    bad2         = seed2 < SEED2_MIN;
    bad3         = seed3 < SEED3_MIN;

    if (seed_load) begin
      // Reseeding wins over any grant of this cycle; that word is dropped.
      seed1_d      = bad1 ? DEF_SEED1 : seed1;
      seed2_d      = bad2 ? DEF_SEED2 : seed2;
      seed3_d      = bad3 ? DEF_SEED3 : seed3;
      seed_err_d   = bad1 | bad2 | bad3;
      state_d      = ST_LOAD;
      gen_rst_d    = 1'b1;
      word_count_d = '0;
      warm_cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          state_d    = ST_WARM;
          warm_cnt_d = 8'(WARMUP - 1);
        end
        ST_WARM: begin
          if (warm_cnt_q == 8'd0) state_d = ST_RUN;
          else                    warm_cnt_d = warm_cnt_q - 8'd1;
        end
        ST_RUN: begin
          if (|req) begin
            rnd_valid_d  = NUM_REQ'(1) << grant;
            rnd_data_d   = gen_rnd;
            word_count_d = word_count_q + 32'd1;
            ptr_d        = (grant == 3'(NUM_REQ - 1)) ? 3'd0 : grant + 3'd1;
          end
        end
        default: begin
          state_d   = ST_LOAD;
          gen_rst_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      warm_cnt_q   <= '0;
      seed1_q      <= DEF_SEED1;
      seed2_q      <= DEF_SEED2;
      seed3_q      <= DEF_SEED3;
      seed_err_q   <= 1'b0;
      gen_rst_q    <= 1'b1;
      rnd_valid_q  <= '0;
      rnd_data_q   <= '0;
      word_count_q <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      seed1_q      <= seed1_d;
      seed2_q      <= seed2_d;
      seed3_q      <= seed3_d;
      seed_err_q   <= seed_err_d;
      gen_rst_q    <= gen_rst_d;
      rnd_valid_q  <= rnd_valid_d;
      rnd_data_q   <= rnd_data_d;
      word_count_q <= word_count_d;
      ptr_q        <= ptr_d;
    end
  end

  assign rnd_valid  = rnd_valid_q;
  assign rnd_data   = rnd_data_q;
  assign rnd_ready  = (state_q == ST_RUN);
  assign seed_err   = seed_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_urng_scheduler.sv
// Bench for urng_scheduler: directed phases plus random request/seed traffic,
// checked every cycle against a behavioural model (taus88 software recurrence,
// cycles-since-load counter, index-order round-robin search).
module tb_urng_scheduler;

  localparam int          N  = 4;
  localparam int          WU = 8;
  localparam logic [31:0] D1 = 32'h0000_1234;
  localparam logic [31:0] D2 = 32'h0000_5678;
  localparam logic [31:0] D3 = 32'h0009_ABCD;

  logic          clk = 1'b0;
  logic          reset, seed_load;
  logic [31:0]   seed1, seed2, seed3;
  logic [N-1:0]  req;
  logic [N-1:0]  rnd_valid;
  logic [31:0]   rnd_data;
  logic          rnd_ready, seed_err;
  logic [31:0]   word_count;

  urng_scheduler #(.NUM_REQ(N), .WARMUP(WU)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_load  (seed_load),
    .seed1      (seed1),
    .seed2      (seed2),
    .seed3      (seed3),
    .req        (req),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .rnd_ready  (rnd_ready),
    .seed_err   (seed_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] m_seed1 = D1, m_seed2 = D2, m_seed3 = D3;
  logic [31:0] m_g0, m_g1, m_g2;
  logic        m_err = 1'b0;
  logic [N-1:0] m_valid = '0;
  logic [31:0] m_data = '0, m_wc = '0;
  int          m_ptr = 0;
  int          m_cnt = 0;   // index of the current cycle since the load cycle (0)

  function automatic logic [31:0] t0(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction
  function automatic logic [31:0] t1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction
  function automatic logic [31:0] t2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  // n-th output (1-based) of taus88 started from the given seeds
  function automatic logic [31:0] golden_nth(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input int n);
    logic [31:0] x, y, z;
    x = a; y = b; z = c;
    for (int i = 0; i < n; i++) begin
      x = t0(x); y = t1(y); z = t2(z);
    end
    return x ^ y ^ z;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model over one clock using the inputs now applied, take the
  // edge, then compare every output.
  task automatic tick();
    logic [31:0] cur;
    int          g;
    if (m_cnt == 0) begin
      m_g0 = m_seed1; m_g1 = m_seed2; m_g2 = m_seed3;
    end
    m_g0 = t0(m_g0); m_g1 = t1(m_g1); m_g2 = t2(m_g2);
    cur  = m_g0 ^ m_g1 ^ m_g2;
    if (!reset) begin
      m_seed1 = D1; m_seed2 = D2; m_seed3 = D3;
      m_err = 1'b0; m_valid = '0; m_data = '0; m_wc = '0; m_ptr = 0; m_cnt = 0;
    end else if (seed_load) begin
      m_seed1 = (seed1 < 2)  ? D1 : seed1;
      m_seed2 = (seed2 < 8)  ? D2 : seed2;
      m_seed3 = (seed3 < 16) ? D3 : seed3;
      m_err   = (seed1 < 2) || (seed2 < 8) || (seed3 < 16);
      m_valid = '0; m_wc = '0; m_cnt = 0;
    end else begin
      m_valid = '0;
      if (m_cnt >= 1 + WU && req != '0) begin
        g = -1;
        for (int j = 0; j < N; j++)
          if (g < 0 && req[(m_ptr + j) % N]) g = (m_ptr + j) % N;
        m_valid = N'(1 << g);
        m_data  = cur;
        m_wc    = m_wc + 32'd1;
        m_ptr   = (g + 1) % N;
      end
      if (m_cnt < 1000) m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("rnd_valid",  32'(rnd_valid), 32'(m_valid));
    chk("rnd_data",   rnd_data, m_data);
    chk("rnd_ready",  32'(rnd_ready), 32'(m_cnt >= 1 + WU));
    chk("seed_err",   32'(seed_err), 32'(m_err));
    chk("word_count", word_count, m_wc);
  endtask

  // Runs 10 cycles from a fresh load with all requests held; checks the
  // ready rise cycle and the first delivered word.
  task automatic startup(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
    int rise;
    rise = 0;
    req  = '1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rnd_ready === 1'b1 && rise == 0) rise = i;
    end
    chk({tag, "_ready_rise"}, 32'(rise), 32'd9);
    chk({tag, "_first_word"}, rnd_data, golden_nth(a, b, c, 10));
    chk({tag, "_first_valid"}, 32'(rnd_valid), 32'h1);
  endtask

  initial begin
    logic [3:0] rr_tab [8];
    rr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset = 1'b0; seed_load = 1'b0; seed1 = '0; seed2 = '0; seed3 = '0; req = '0;

    // reset values
    repeat (3) tick();
    chk("reset_data", rnd_data, 32'd0);
    chk("reset_ready", 32'(rnd_ready), 32'd0);

    // bring-up with default seeds, then fairness with all requesting
    reset = 1'b1;
    startup("boot", D1, D2, D3);
    chk("rr_seq0", 32'(rnd_valid), 32'(rr_tab[0]));
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("rr_seq", 32'(rnd_valid), 32'(rr_tab[i]));
    end
    chk("rr_count8", word_count, 32'd8);

    // pointer wrap
    req = 4'b0100; tick(); chk("wrap_g2", 32'(rnd_valid), 32'b0100);
    req = 4'b1001; tick(); chk("wrap_g3", 32'(rnd_valid), 32'b1000);
    tick();                chk("wrap_g0", 32'(rnd_valid), 32'b0001);
    req = 4'b0000; tick(); chk("idle_hold", 32'(rnd_valid), 32'd0);

    repeat (40) begin
      req = 4'($urandom_range(0, 15));
      tick();
    end

    // illegal seeds mid-RUN with all requesting
    req = '1; seed1 = 32'd1; seed2 = 32'd100; seed3 = 32'd5; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("sl_valid", 32'(rnd_valid), 32'd0);
    chk("sl_count", word_count, 32'd0);
    chk("sl_err", 32'(seed_err), 32'd1);
    chk("sl_ready", 32'(rnd_ready), 32'd0);
    // the load cycle itself is the first of the 10 generator cycles
    begin
      int rise;
      rise = 0;
      for (int i = 1; i <= 9; i++) begin
        tick();
        if (rnd_ready === 1'b1 && rise == 0) rise = i;
      end
      chk("sl_ready_rise", 32'(rise), 32'd9);
      tick();
      chk("sl_first_word", rnd_data, golden_nth(D1, 32'd100, D3, 10));
    end

    repeat (20) begin
      req = 4'($urandom_range(0, 15));
      tick();
    end

    // legal boundary seeds clear the error
    seed1 = 32'd2; seed2 = 32'd8; seed3 = 32'd16; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("legal_err", 32'(seed_err), 32'd0);
    repeat (12) begin
      req = 4'($urandom_range(0, 15));
      tick();
    end

    // random traffic with occasional reseeds
    repeat (150) begin
      req       = 4'($urandom_range(0, 15));
      seed_load = ($urandom_range(0, 24) == 0);
      seed1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))  : $urandom();
      seed2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))  : $urandom();
      seed3 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 17)) : $urandom();
      tick();
    end
    seed_load = 1'b0;
    req = '1;
    repeat (12) tick();

    // one-cycle reset mid-RUN, seed_load also high to show reset priority
    reset = 1'b0; seed_load = 1'b1; seed1 = 32'hDEAD_BEEF;
    tick();
    seed_load = 1'b0;
    chk("rst_valid", 32'(rnd_valid), 32'd0);
    chk("rst_data", rnd_data, 32'd0);
    chk("rst_err", 32'(seed_err), 32'd0);
    chk("rst_count", word_count, 32'd0);
    reset = 1'b1;
    startup("rerun", D1, D2, D3);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
